frame_tick_scheduler: RTL and testbench

- Turns in_clk into a programmable-rate frame tick, using a one-cycle enable pulse rather than a divided clock.
- On each accepted tick, sequences the game-update phases (0 = paddle, 1 = ball, 2 = collision/score) in a fixed order, using a go/done handshake per phase.
- Sits between the top-level clock and the game-logic units, and replaces ad-hoc divided clocks with a single clock domain.
- Reports frame count, dropped ticks (overruns) and phase timeouts.

---
 rtl/frame_pkg.sv | 18 +
 rtl/tick_gen.sv | 39 +++
 rtl/frame_tick_scheduler.sv | 133 +++++++++++++
 tb/tb_frame_tick_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame tick scheduler: FSM encoding, phase indices
// and divider defaults.
package frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    localparam int unsigned PH_PADDLE  = 0;
    localparam int unsigned PH_BALL    = 1;
    localparam int unsigned PH_COLLIDE = 2;

    localparam int unsigned DIV_DEFAULT = 50000;
    localparam int unsigned MIN_DIV     = 2;

endpackage

// File: rtl/tick_gen.sv
// Programmable divider producing a one-cycle enable pulse every div_reg cycles.
// A divisor load restarts the period and swallows any coincident tick.
module tick_gen #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DIV_DEFAULT = frame_pkg::DIV_DEFAULT,
    parameter int unsigned MIN_DIV     = frame_pkg::MIN_DIV
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    input  logic             enable,
    output logic             tick_out
);
    import frame_pkg::*;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_clamped;
    logic             w_wrap;

    assign w_div_clamped = (div_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_val;
    assign w_wrap        = (r_count == (r_div - CNT_W'(1)));
    assign tick_out      = enable && w_wrap && !div_load;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_div   <= CNT_W'(DIV_DEFAULT);
        end else if (div_load) begin
            // Loads apply even while disabled so software can reprogram a stopped divider.
            r_div   <= w_div_clamped;
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_tick_scheduler.sv
// Frame tick scheduler: divider tick starts a frame that sequences the game-update
// phases with a go/done handshake, tracking frames, dropped ticks and phase timeouts.
module frame_tick_scheduler #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DIV_DEFAULT = frame_pkg::DIV_DEFAULT,
    parameter int unsigned MIN_DIV     = frame_pkg::MIN_DIV,
    parameter int unsigned N_PHASE     = 3,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic               in_clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   div_val,
    input  logic               div_load,
    input  logic               enable,
    input  logic               pause,
    output logic               tick_out,
    output logic [N_PHASE-1:0] phase_go,
    input  logic [N_PHASE-1:0] phase_done,
    output logic               frame_busy,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         overrun_cnt,
    output logic               timeout_err
);
    import frame_pkg::*;

    localparam int unsigned       IDX_W     = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_PHASE - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    function automatic logic [N_PHASE-1:0] phase_onehot(input logic [IDX_W-1:0] idx);
        phase_onehot      = '0;
        phase_onehot[idx] = 1'b1;
    endfunction

    state_e              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [WAIT_W-1:0]   r_wait;
    logic [N_PHASE-1:0]  r_go;
    logic                r_busy;
    logic [15:0]         r_frame_cnt;
    logic [7:0]          r_overrun;
    logic                r_timeout;

    logic w_tick;
    logic w_done;
    logic w_expired;
    logic w_overrun;

    tick_gen #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .MIN_DIV     (MIN_DIV)
    ) u_tick_gen (
        .in_clk   (in_clk),
        .rst_n    (rst_n),
        .div_val  (div_val),
        .div_load (div_load),
        .enable   (enable),
        .tick_out (w_tick)
    );

    assign w_done    = phase_done[r_idx];
    assign w_expired = (r_wait == WAIT_LAST);
    // Ticks are never queued: any tick not starting a frame is a drop.
    assign w_overrun = w_tick && ((r_state != StIdle) || pause);

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_wait      <= '0;
            r_go        <= '0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_go <= '0;
            case (r_state)
                StIdle: begin
                    if (w_tick && !pause) begin
                        r_idx   <= IDX_W'(PH_PADDLE);
                        r_go    <= phase_onehot(IDX_W'(PH_PADDLE));
                        r_state <= StIssue;
                        r_busy  <= 1'b1;
                    end
                end
                StIssue: begin
                    r_wait  <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (w_done || w_expired) begin
                        if (!w_done) begin
                            r_timeout <= 1'b1;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= StIdle;
                            r_busy      <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_go    <= phase_onehot(r_idx + IDX_W'(1));
                            r_state <= StIssue;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= '0;
        end else if (w_overrun && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign tick_out    = w_tick;
    assign phase_go    = r_go;
    assign frame_busy  = r_busy;
    assign frame_cnt   = r_frame_cnt;
    assign overrun_cnt = r_overrun;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// Directed bench for frame_tick_scheduler: per-cycle divider vector table plus
// hand-written frame, overrun, timeout, pause and reset sequences.
module tb_frame_tick_scheduler;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned N_PHASE = 3;
    localparam int unsigned TIMEOUT = 15;

    logic               in_clk = 1'b0;
    logic               rst_n;
    logic [CNT_W-1:0]   div_val;
    logic               div_load;
    logic               enable;
    logic               pause;
    logic               tick_out;
    logic [N_PHASE-1:0] phase_go;
    logic [N_PHASE-1:0] phase_done;
    logic               frame_busy;
    logic [15:0]        frame_cnt;
    logic [7:0]         overrun_cnt;
    logic               timeout_err;

    bit                 resp_en;
    int                 resp_dly;
    logic [N_PHASE-1:0] resp_mask;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] val;
        logic        ld;
        logic        en;
        logic        pz;
        logic        exp_tick;
    } vec_t;

    vec_t vecs[$];

    always #5 in_clk = ~in_clk;

    frame_tick_scheduler #(
        .CNT_W   (CNT_W),
        .N_PHASE (N_PHASE),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .in_clk      (in_clk),
        .rst_n       (rst_n),
        .div_val     (div_val),
        .div_load    (div_load),
        .enable      (enable),
        .pause       (pause),
        .tick_out    (tick_out),
        .phase_go    (phase_go),
        .phase_done  (phase_done),
        .frame_busy  (frame_busy),
        .frame_cnt   (frame_cnt),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    // Phase responder: pulses done for the issued phase resp_dly cycles after its go.
    initial begin
        logic [N_PHASE-1:0] r;
        phase_done = '0;
        forever begin
            @(negedge in_clk);
            if (resp_en && (phase_go != '0) && ((phase_go & resp_mask) != '0)) begin
                r = phase_go;
                repeat (resp_dly) @(posedge in_clk);
                #1 phase_done = r;
                @(posedge in_clk);
                #1 phase_done = '0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] v, input logic ld, input logic en,
                           input logic pz, input logic et);
        vec_t e;
        e.val = v; e.ld = ld; e.en = en; e.pz = pz; e.exp_tick = et;
        vecs.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        div_val  = '0;
        div_load = 1'b0;
        enable   = 1'b0;
        pause    = 1'b0;
        resp_en  = 1'b0;
        repeat (2) @(posedge in_clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_go(input logic [N_PHASE-1:0] exp, input int budget,
                           input string name, output int n);
        n = 0;
        do begin
            @(negedge in_clk);
            n++;
        end while ((phase_go == '0) && (n < budget));
        chk(name, 32'(phase_go), 32'(exp));
    endtask

    task automatic wait_busy_fall(input int budget, input string name);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        while (n < budget) begin
            @(negedge in_clk);
            n++;
            if (frame_busy) seen = 1'b1;
            else if (seen) break;
        end
        chk(name, {31'b0, seen && !frame_busy}, 32'd1);
    endtask

    initial begin
        int n;
        int exp_ovr;
        int ticks_seen;
        bit go_seen;

        resp_dly  = 3;
        resp_mask = '1;

        // Divider table: pause held high so every tick counts as a drop.
        add_vec(10, 1, 1, 1, 0);
        for (int i = 1; i <= 20; i++) add_vec(0, 0, 1, 1, (i % 10) == 0);
        add_vec(0, 1, 1, 1, 0);
        for (int j = 1; j <= 6; j++) add_vec(0, 0, 1, 1, (j % 2) == 0);
        add_vec(0, 0, 1, 1, 0);
        add_vec(1, 1, 1, 1, 0);
        add_vec(0, 0, 1, 1, 0);
        add_vec(0, 0, 1, 1, 1);
        add_vec(0, 0, 1, 1, 0);
        add_vec(0, 0, 0, 1, 0);
        add_vec(0, 0, 0, 1, 0);
        add_vec(0, 0, 1, 1, 1);
        add_vec(4, 1, 0, 1, 0);
        add_vec(0, 0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) add_vec(0, 0, 1, 1, k == 4);

        apply_reset();
        @(negedge in_clk);
        chk("rst tick", tick_out, 0);
        chk("rst go", phase_go, 0);
        chk("rst busy", frame_busy, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        chk("rst overrun", overrun_cnt, 0);
        chk("rst timeout", timeout_err, 0);

        exp_ovr = 0;
        foreach (vecs[i]) begin
            @(posedge in_clk);
            #1;
            div_val  = vecs[i].val;
            div_load = vecs[i].ld;
            enable   = vecs[i].en;
            pause    = vecs[i].pz;
            @(negedge in_clk);
            chk($sformatf("tbl[%0d] tick", i), tick_out, vecs[i].exp_tick);
            chk($sformatf("tbl[%0d] go", i), phase_go, 0);
            if (vecs[i].exp_tick) exp_ovr++;
        end
        @(negedge in_clk);
        chk("tbl overrun", overrun_cnt, exp_ovr);
        chk("tbl busy", frame_busy, 0);

        // Normal frames: divisor 20, done 3 cycles after each go.
        apply_reset();
        @(posedge in_clk);
        #1 div_val = 20; div_load = 1'b1; enable = 1'b1; resp_dly = 3; resp_en = 1'b1;
        @(posedge in_clk);
        #1 div_load = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_go(3'b001, 40, $sformatf("frm%0d go0", f), n);
            chk($sformatf("frm%0d busy", f), frame_busy, 1);
            wait_go(3'b010, 10, $sformatf("frm%0d go1", f), n);
            chk($sformatf("frm%0d gap1", f), n, 4);
            wait_go(3'b100, 10, $sformatf("frm%0d go2", f), n);
            chk($sformatf("frm%0d gap2", f), n, 4);
            wait_busy_fall(10, $sformatf("frm%0d idle", f));
            chk($sformatf("frm%0d cnt", f), frame_cnt, f + 1);
        end
        chk("frm overrun", overrun_cnt, 0);

        // Slow responders: 40-cycle frames against a 5-cycle tick drop 7 ticks per frame.
        apply_reset();
        @(posedge in_clk);
        #1 div_val = 5; div_load = 1'b1; enable = 1'b1; resp_dly = 12; resp_en = 1'b1;
        @(posedge in_clk);
        #1 div_load = 1'b0;
        wait_busy_fall(80, "ovr idle1");
        chk("ovr cnt1", overrun_cnt, 7);
        chk("ovr frame1", frame_cnt, 1);
        wait_busy_fall(80, "ovr idle2");
        chk("ovr cnt2", overrun_cnt, 14);
        chk("ovr frame2", frame_cnt, 2);
        repeat (1600) @(negedge in_clk);
        chk("ovr sat", overrun_cnt, 255);
        chk("ovr timeout", timeout_err, 0);

        // Phase 1 never answers: abort after TIMEOUT wait cycles, then finish the frame.
        apply_reset();
        @(posedge in_clk);
        #1 div_val = 20; div_load = 1'b1; enable = 1'b1;
        resp_dly = 3; resp_mask = 3'b101; resp_en = 1'b1;
        @(posedge in_clk);
        #1 div_load = 1'b0;
        wait_go(3'b001, 40, "to go0", n);
        wait_go(3'b010, 10, "to go1", n);
        chk("to err before", timeout_err, 0);
        wait_go(3'b100, 40, "to go2", n);
        chk("to gap", n, TIMEOUT + 1);
        chk("to err", timeout_err, 1);
        wait_busy_fall(10, "to idle");
        chk("to frame", frame_cnt, 1);
        chk("to overrun", overrun_cnt, 1);
        resp_mask = '1;

        // Pause across three ticks, then an asynchronous reset in the middle of WAIT.
        apply_reset();
        @(posedge in_clk);
        #1 div_val = 5; div_load = 1'b1; enable = 1'b1; pause = 1'b1;
        @(posedge in_clk);
        #1 div_load = 1'b0;
        ticks_seen = 0;
        go_seen    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge in_clk);
            if (tick_out) ticks_seen++;
            if (phase_go != '0) go_seen = 1'b1;
        end
        chk("pz ticks", ticks_seen, 3);
        chk("pz no go", go_seen, 0);
        chk("pz overrun", overrun_cnt, 3);
        @(posedge in_clk);
        #1 pause = 1'b0; resp_dly = 3; resp_en = 1'b1;
        wait_go(3'b001, 20, "pz go0", n);
        @(posedge in_clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst busy", frame_busy, 0);
        chk("arst go", phase_go, 0);
        chk("arst overrun", overrun_cnt, 0);
        chk("arst frame", frame_cnt, 0);
        chk("arst timeout", timeout_err, 0);
        chk("arst tick", tick_out, 0);
        resp_en = 1'b0;
        @(posedge in_clk);
        #2 rst_n = 1'b1;
        go_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge in_clk);
            if (phase_go != '0) go_seen = 1'b1;
        end
        chk("arst no go", go_seen, 0);
        chk("arst idle", frame_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
